// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the simple-RISC datapath.
// Moore FSM: the EXEC variants are separate states so that every output
// depends only on the current state, never on the opcode inputs.
module datapath_sequencer #(
  parameter int MEM_TIMEOUT   = 15,
  parameter bit STATUS_ON_ALU = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  input  logic [1:0] shift_op,
  input  logic       mem_ready,
  output logic       waiting,
  output logic       halted,
  output logic       err,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_ir,
  output logic       load_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd
);

  typedef enum logic [4:0] {
    S_WAIT, S_FETCH, S_LOAD_IR, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
    S_EXEC_ALU, S_EXEC_CMP, S_EXEC_MOV, S_EXEC_MVN, S_WB, S_ADDR,
    S_LD_ADDR, S_MEM_RD, S_LD_WB, S_ST_B, S_ST_C, S_MEM_WR, S_HALT, S_ERR
  } state_t;

  // Counter value seen during the last permitted cycle in a memory state.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, next;
  logic [7:0] wait_cnt;
  logic       in_mem, timed_out;

  // shift_op is routed to the shifter by the datapath; it is not decoded here.
  logic unused;
  assign unused = ^shift_op;

  assign in_mem    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timed_out = !mem_ready && (wait_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= next;
  end

  // Wait counter: counts stalled cycles, restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wait_cnt <= 8'd0;
    else if (in_mem && next == state) wait_cnt <= wait_cnt + 8'd1;
    else                            wait_cnt <= 8'd0;
  end

  // Next-state logic; opcode/ALU_op are held stable from DECODE to retire.
  always_comb begin
    next = state;
    case (state)
      S_WAIT:    if (start) next = S_FETCH;
      S_FETCH:   if (mem_ready) next = S_LOAD_IR; else if (timed_out) next = S_ERR;
      S_LOAD_IR: next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          3'b110: begin
            case (ALU_op)
              2'b10:   next = S_WR_IMM;
              2'b00:   next = S_GET_B;
              default: next = S_ERR;
            endcase
          end
          3'b101:         next = (ALU_op == 2'b11) ? S_GET_B : S_GET_A;
          3'b011, 3'b100: next = S_GET_A;
          3'b111:         next = S_HALT;
          default:        next = S_ERR;
        endcase
      end
      S_WR_IMM:  next = S_WAIT;
      S_GET_A:   next = (opcode == 3'b101) ? S_GET_B : S_ADDR;
      S_GET_B: begin
        if (opcode == 3'b110) next = S_EXEC_MOV;
        else begin
          case (ALU_op)
            2'b01:   next = S_EXEC_CMP;
            2'b11:   next = S_EXEC_MVN;
            default: next = S_EXEC_ALU;
          endcase
        end
      end
      S_EXEC_ALU, S_EXEC_MOV, S_EXEC_MVN: next = S_WB;
      S_EXEC_CMP: next = S_WAIT;
      S_WB:       next = S_WAIT;
      S_ADDR:     next = S_LD_ADDR;
      S_LD_ADDR:  next = (opcode == 3'b100) ? S_ST_B : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) next = S_LD_WB; else if (timed_out) next = S_ERR;
      S_LD_WB:    next = S_WAIT;
      S_ST_B:     next = S_ST_C;
      S_ST_C:     next = S_MEM_WR;
      S_MEM_WR:   if (mem_ready) next = S_WAIT; else if (timed_out) next = S_ERR;
      S_HALT:     next = S_HALT;
      S_ERR:      next = S_ERR;
      default:    next = S_WAIT;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    waiting = 1'b0; halted = 1'b0; err = 1'b0;
    reg_sel = 2'b00; wb_sel = 2'b00; w_en = 1'b0;
    en_A = 1'b0; en_B = 1'b0; en_C = 1'b0; en_status = 1'b0;
    sel_A = 1'b0; sel_B = 1'b0;
    load_ir = 1'b0; load_pc = 1'b0; load_addr = 1'b0;
    addr_sel = 1'b0; mem_cmd = 2'b00;
    case (state)
      S_WAIT:     waiting = 1'b1;
      S_FETCH:    begin addr_sel = 1'b1; mem_cmd = 2'b01; end
      S_LOAD_IR:  begin load_ir = 1'b1; load_pc = 1'b1; end
      S_WR_IMM:   begin reg_sel = 2'b10; wb_sel = 2'b10; w_en = 1'b1; end
      S_GET_A:    begin reg_sel = 2'b10; en_A = 1'b1; end
      S_GET_B:    begin reg_sel = 2'b00; en_B = 1'b1; end
      S_EXEC_ALU: begin en_C = 1'b1; en_status = STATUS_ON_ALU; end
      S_EXEC_CMP: en_status = 1'b1;
      S_EXEC_MOV: begin en_C = 1'b1; sel_A = 1'b1; end
      S_EXEC_MVN: begin en_C = 1'b1; sel_A = 1'b1; en_status = STATUS_ON_ALU; end
      S_WB:       begin reg_sel = 2'b01; wb_sel = 2'b00; w_en = 1'b1; end
      S_ADDR:     begin en_C = 1'b1; sel_B = 1'b1; end
      S_LD_ADDR:  load_addr = 1'b1;
      S_MEM_RD:   begin addr_sel = 1'b0; mem_cmd = 2'b01; end
      S_LD_WB:    begin reg_sel = 2'b01; wb_sel = 2'b11; w_en = 1'b1; end
      S_ST_B:     begin reg_sel = 2'b01; en_B = 1'b1; end
      S_ST_C:     begin en_C = 1'b1; sel_A = 1'b1; end
      S_MEM_WR:   begin addr_sel = 1'b0; mem_cmd = 2'b10; end
      S_HALT:     halted = 1'b1;
      S_ERR:      err = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench: two sequencers (STATUS_ON_ALU 0 and 1, MEM_TIMEOUT 4)
// share stimulus; every cycle both output words are compared to the
// hand-built per-state expectations below.
module tb_datapath_sequencer;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mem_ready = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] ALU_op = 2'b00, shift_op = 2'b01;
  int vec = 0, errs = 0;

  always #5 clk = ~clk;

  // Output bit positions inside the packed observation word.
  localparam logic [19:0] WAITING = 20'h80000, HALTED = 20'h40000, ERRB = 20'h20000,
    RS_RD = 20'h08000, RS_RN = 20'h10000, WB_IMM = 20'h04000, WB_MD = 20'h06000,
    W_EN = 20'h01000, EN_A = 20'h00800, EN_B = 20'h00400, EN_C = 20'h00200,
    EN_ST = 20'h00100, SEL_A = 20'h00080, SEL_B = 20'h00040, LD_IR = 20'h00020,
    LD_PC = 20'h00010, LD_AD = 20'h00008, A_PC = 20'h00004, RD = 20'h00001, WR = 20'h00002;

  localparam logic [19:0] E_WAIT = WAITING, E_FETCH = A_PC | RD, E_LIR = LD_IR | LD_PC,
    E_DEC = 20'h0, E_IMM = RS_RN | WB_IMM | W_EN, E_GA = RS_RN | EN_A, E_GB = EN_B,
    E_EXA = EN_C, E_EXCMP = EN_ST, E_EXMOV = EN_C | SEL_A, E_WB = RS_RD | W_EN,
    E_ADDR = EN_C | SEL_B, E_LDA = LD_AD, E_MRD = RD, E_LWB = RS_RD | WB_MD | W_EN,
    E_STB = RS_RD | EN_B, E_STC = EN_C | SEL_A, E_MWR = WR, E_HALT = HALTED, E_ERR = ERRB;

  logic wt0, ht0, er0, we0, ea0, eb0, ec0, es0, sa0, sb0, li0, lp0, la0, as0;
  logic wt1, ht1, er1, we1, ea1, eb1, ec1, es1, sa1, sb1, li1, lp1, la1, as1;
  logic [1:0] rs0, wb0, mc0, rs1, wb1, mc1;
  logic [19:0] obs0, obs1;

  assign obs0 = {wt0, ht0, er0, rs0, wb0, we0, ea0, eb0, ec0, es0, sa0, sb0, li0, lp0, la0, as0, mc0};
  assign obs1 = {wt1, ht1, er1, rs1, wb1, we1, ea1, eb1, ec1, es1, sa1, sb1, li1, lp1, la1, as1, mc1};

  datapath_sequencer #(.MEM_TIMEOUT(4), .STATUS_ON_ALU(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(ALU_op),
    .shift_op(shift_op), .mem_ready(mem_ready), .waiting(wt0), .halted(ht0), .err(er0),
    .reg_sel(rs0), .wb_sel(wb0), .w_en(we0), .en_A(ea0), .en_B(eb0), .en_C(ec0),
    .en_status(es0), .sel_A(sa0), .sel_B(sb0), .load_ir(li0), .load_pc(lp0),
    .load_addr(la0), .addr_sel(as0), .mem_cmd(mc0));

  datapath_sequencer #(.MEM_TIMEOUT(4), .STATUS_ON_ALU(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(ALU_op),
    .shift_op(shift_op), .mem_ready(mem_ready), .waiting(wt1), .halted(ht1), .err(er1),
    .reg_sel(rs1), .wb_sel(wb1), .w_en(we1), .en_A(ea1), .en_B(eb1), .en_C(ec1),
    .en_status(es1), .sel_A(sa1), .sel_B(sb1), .load_ir(li1), .load_pc(lp1),
    .load_addr(la1), .addr_sel(as1), .mem_cmd(mc1));

  task automatic chk(input string tag, input logic [19:0] o, input logic [19:0] e);
    vec++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
    end
  endtask

  // Compare both instances now (no clock edge).
  task automatic now(input string tag, input logic [19:0] e0, input logic [19:0] e1);
    chk({tag, "/s0"}, obs0, e0);
    chk({tag, "/s1"}, obs1, e1);
  endtask

  // Advance to the next falling edge, then compare.
  task automatic cyc(input string tag, input logic [19:0] e0, input logic [19:0] e1);
    @(negedge clk);
    now(tag, e0, e1);
  endtask

  // Issue an instruction from WAIT and check the FETCH cycle, LOAD_IR and DECODE.
  task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] aop);
    opcode = op; ALU_op = aop; start = 1'b1;
    cyc({tag, ".fetch"}, E_FETCH, E_FETCH);
    start = 1'b0;
    cyc({tag, ".ldir"}, E_LIR, E_LIR);
    cyc({tag, ".dec"}, E_DEC, E_DEC);
  endtask

  task automatic do_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 now(tag, E_WAIT, E_WAIT);
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 now("reset", E_WAIT, E_WAIT);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    cyc("idle", E_WAIT, E_WAIT);

    // MOV imm: back in WAIT 4 edges after the start edge.
    issue("movi", 3'b110, 2'b10);
    cyc("movi.wr", E_IMM, E_IMM);
    cyc("movi.done", E_WAIT, E_WAIT);

    // ADD: status only in the STATUS_ON_ALU=1 instance.
    issue("add", 3'b101, 2'b00);
    cyc("add.ga", E_GA, E_GA);
    cyc("add.gb", E_GB, E_GB);
    cyc("add.ex", E_EXA, E_EXA | EN_ST);
    cyc("add.wb", E_WB, E_WB);
    cyc("add.done", E_WAIT, E_WAIT);

    // CMP: status in both, no C, no write-back.
    issue("cmp", 3'b101, 2'b01);
    cyc("cmp.ga", E_GA, E_GA);
    cyc("cmp.gb", E_GB, E_GB);
    cyc("cmp.ex", E_EXCMP, E_EXCMP);
    cyc("cmp.done", E_WAIT, E_WAIT);

    // MVN: skips GET_A, zero into A.
    issue("mvn", 3'b101, 2'b11);
    cyc("mvn.gb", E_GB, E_GB);
    cyc("mvn.ex", E_EXMOV, E_EXMOV | EN_ST);
    cyc("mvn.wb", E_WB, E_WB);
    cyc("mvn.done", E_WAIT, E_WAIT);

    // MOV reg: never touches status.
    issue("movr", 3'b110, 2'b00);
    cyc("movr.gb", E_GB, E_GB);
    cyc("movr.ex", E_EXMOV, E_EXMOV);
    cyc("movr.wb", E_WB, E_WB);
    cyc("movr.done", E_WAIT, E_WAIT);

    // AND.
    issue("and", 3'b101, 2'b10);
    cyc("and.ga", E_GA, E_GA);
    cyc("and.gb", E_GB, E_GB);
    cyc("and.ex", E_EXA, E_EXA | EN_ST);
    cyc("and.wb", E_WB, E_WB);
    cyc("and.done", E_WAIT, E_WAIT);

    // LDR with 3 stalled cycles; ready arrives in cycle 4 (= timeout cycle).
    issue("ldr", 3'b011, 2'b00);
    cyc("ldr.ga", E_GA, E_GA);
    cyc("ldr.addr", E_ADDR, E_ADDR);
    cyc("ldr.lda", E_LDA, E_LDA);
    mem_ready = 1'b0;
    cyc("ldr.rd1", E_MRD, E_MRD);
    cyc("ldr.rd2", E_MRD, E_MRD);
    cyc("ldr.rd3", E_MRD, E_MRD);
    cyc("ldr.rd4", E_MRD, E_MRD);
    mem_ready = 1'b1;
    cyc("ldr.wb", E_LWB, E_LWB);
    cyc("ldr.done", E_WAIT, E_WAIT);

    // STR with ready in cycle 4: normal completion.
    issue("str", 3'b100, 2'b00);
    cyc("str.ga", E_GA, E_GA);
    cyc("str.addr", E_ADDR, E_ADDR);
    cyc("str.lda", E_LDA, E_LDA);
    cyc("str.stb", E_STB, E_STB);
    cyc("str.stc", E_STC, E_STC);
    mem_ready = 1'b0;
    cyc("str.wr1", E_MWR, E_MWR);
    cyc("str.wr2", E_MWR, E_MWR);
    cyc("str.wr3", E_MWR, E_MWR);
    cyc("str.wr4", E_MWR, E_MWR);
    mem_ready = 1'b1;
    cyc("str.done", E_WAIT, E_WAIT);

    // STR with memory stuck: exactly 4 MEM_WR cycles then ERR.
    issue("tmo", 3'b100, 2'b00);
    cyc("tmo.ga", E_GA, E_GA);
    cyc("tmo.addr", E_ADDR, E_ADDR);
    cyc("tmo.lda", E_LDA, E_LDA);
    cyc("tmo.stb", E_STB, E_STB);
    mem_ready = 1'b0;
    cyc("tmo.stc", E_STC, E_STC);
    cyc("tmo.wr1", E_MWR, E_MWR);
    cyc("tmo.wr2", E_MWR, E_MWR);
    cyc("tmo.wr3", E_MWR, E_MWR);
    cyc("tmo.wr4", E_MWR, E_MWR);
    cyc("tmo.err", E_ERR, E_ERR);
    start = 1'b1; mem_ready = 1'b1;
    cyc("tmo.hold1", E_ERR, E_ERR);
    cyc("tmo.hold2", E_ERR, E_ERR);
    do_reset("tmo.rst");
    cyc("tmo.idle", E_WAIT, E_WAIT);

    // Stalled FETCH also times out.
    opcode = 3'b110; ALU_op = 2'b10; start = 1'b1; mem_ready = 1'b0;
    cyc("ftmo.f1", E_FETCH, E_FETCH);
    start = 1'b0;
    cyc("ftmo.f2", E_FETCH, E_FETCH);
    cyc("ftmo.f3", E_FETCH, E_FETCH);
    cyc("ftmo.f4", E_FETCH, E_FETCH);
    cyc("ftmo.err", E_ERR, E_ERR);
    do_reset("ftmo.rst");

    // Illegal opcode.
    issue("ill", 3'b010, 2'b00);
    cyc("ill.err", E_ERR, E_ERR);
    cyc("ill.hold", E_ERR, E_ERR);
    do_reset("ill.rst");

    // MOV with ALU_op x1 is illegal too.
    issue("ill2", 3'b110, 2'b01);
    cyc("ill2.err", E_ERR, E_ERR);
    do_reset("ill2.rst");

    // HALT absorbs, ignoring start.
    issue("halt", 3'b111, 2'b00);
    cyc("halt.h", E_HALT, E_HALT);
    start = 1'b1;
    cyc("halt.hold", E_HALT, E_HALT);
    start = 1'b0;
    do_reset("halt.rst");
    cyc("halt.idle", E_WAIT, E_WAIT);

    // Asynchronous reset mid-FETCH: command dropped without an edge.
    opcode = 3'b110; ALU_op = 2'b10; start = 1'b1;
    cyc("arf.fetch", E_FETCH, E_FETCH);
    start = 1'b0;
    do_reset("arf.rst");

    // Asynchronous reset mid-EXEC.
    issue("are", 3'b101, 2'b00);
    cyc("are.ga", E_GA, E_GA);
    cyc("are.gb", E_GB, E_GB);
    cyc("are.ex", E_EXA, E_EXA | EN_ST);
    do_reset("are.rst");
    cyc("are.idle", E_WAIT, E_WAIT);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Parametrised multi-cycle sequencer for the simple-RISC datapath. It fetches each instruction over a ready-handshaked memory port, decodes it, and drives the register-file, A/B/C, status, PC, IR and address-register enables. It replaces the start-only ALU/MOV controller, adding these behaviours:

- LDR, STR and HALT instructions.
- Illegal-opcode and memory-timeout error trapping.
- A mode that lets ALU writes also update the status flags.

## Interface
- MEM_TIMEOUT, default 15: maximum cycles spent in one memory state without `mem_ready`; range 1..255.
- STATUS_ON_ALU, default 0: when 1, ADD/AND/MVN also assert `en_status` in EXEC; CMP always does.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one instruction; sampled only in WAIT.
- opcode  in  3  IR[15:13]; must be stable from DECODE until the instruction retires.
- ALU_op  in  2  IR[12:11]; sub-op for opcodes 101 and 110.
- shift_op  in  2  IR[4:3]; not decoded, passed through to the shifter by the datapath.
- mem_ready  in  1  memory has completed the current read or write.
- waiting  out  1  idle in WAIT.
- halted  out  1  in HALT.
- err  out  1  in ERR.
- reg_sel  out  2  register field select: 00 Rm, 01 Rd, 10 Rn.
- wb_sel  out  2  write-back source: 00 C, 10 sximm8, 11 mdata; 01 is never driven.
- w_en  out  1  register file write.
- en_A, en_B, en_C, en_status  out  1 each  load-enables for A, B, C and status.
- sel_A  out  1  1 = feed zero instead of A into the ALU.
- sel_B  out  1  1 = feed sximm5 instead of shifted B into the ALU.
- load_ir, load_pc, load_addr  out  1 each  load-enables; `load_pc` loads PC+1.
- addr_sel  out  1  memory address source: 1 = PC, 0 = data address register.
- mem_cmd  out  2  memory command: 00 none, 01 read, 10 write.

## Operation
- Moore FSM: every output is a function of the current state and STATUS_ON_ALU only.
- Any output not listed for a state is 0.
- States and their outputs:
  - WAIT: `waiting` = 1.
  - FETCH: `addr_sel` = 1, `mem_cmd` = 01.
  - LOAD_IR: `load_ir` = 1, `load_pc` = 1.
  - DECODE: no outputs.
  - WR_IMM: `reg_sel` = 10, `wb_sel` = 10, `w_en` = 1.
  - GET_A: `reg_sel` = 10, `en_A` = 1.
  - GET_B: `reg_sel` = 00, `en_B` = 1.
  - EXEC: `en_C` = 1; `sel_A` = 1 for MOV-reg and MVN; `en_status` = 1 for CMP, or for ADD/AND/MVN when STATUS_ON_ALU = 1; `en_C` = 0 for CMP.
  - WB: `reg_sel` = 01, `wb_sel` = 00, `w_en` = 1.
  - ADDR: `en_C` = 1, `sel_B` = 1.
  - LD_ADDR: `load_addr` = 1.
  - MEM_RD: `addr_sel` = 0, `mem_cmd` = 01.
  - LD_WB: `reg_sel` = 01, `wb_sel` = 11, `w_en` = 1.
  - ST_B: `reg_sel` = 01, `en_B` = 1.
  - ST_C: `en_C` = 1, `sel_A` = 1.
  - MEM_WR: `addr_sel` = 0, `mem_cmd` = 10.
  - HALT: `halted` = 1.
  - ERR: `err` = 1.
- Sequences after WAIT → FETCH → LOAD_IR → DECODE:
  - 110/10 (MOV imm): WR_IMM → WAIT.
  - 110/00 (MOV reg): GET_B → EXEC → WB → WAIT.
  - 110/x1: ERR.
  - 101/00 (ADD) and 101/10 (AND): GET_A → GET_B → EXEC → WB → WAIT.
  - 101/01 (CMP): GET_A → GET_B → EXEC → WAIT.
  - 101/11 (MVN): GET_B → EXEC → WB → WAIT.
  - 011 (LDR): GET_A → ADDR → LD_ADDR → MEM_RD → LD_WB → WAIT.
  - 100 (STR): GET_A → ADDR → LD_ADDR → ST_B → ST_C → MEM_WR → WAIT.
  - 111: HALT.
  - 000, 001, 010: ERR.
- Memory states (FETCH, MEM_RD, MEM_WR):
  - 8-bit wait counter, cleared on entry to any memory state.
  - State advances on the edge where `mem_ready` = 1.
  - Otherwise the counter increments; if this was cycle MEM_TIMEOUT in the state, the next state is ERR.
  - `mem_ready` = 1 in the timeout cycle wins: the state advances normally.
- HALT and ERR are absorbing; only `rst_n` exits them. `start` is ignored in every state except WAIT.

## Timing
- While `rst_n` = 0, asynchronously: state = WAIT, counter = 0, `waiting` = 1, every other output 0. This applies mid-instruction too; an interrupted memory command is dropped in the same cycle.
- `start` = 1 sampled in WAIT moves to FETCH at that edge.
- Latency with `mem_ready` tied to 1, counted in edges from the start edge to the return to WAIT: MOV imm 4, MOV reg 6, CMP 6, ADD/AND 7, MVN 6, LDR 8, STR 9.
- Each memory cycle with `mem_ready` = 0 adds one edge.
- `mem_cmd` is held constant for the whole stay in a memory state.
- Exactly one `w_en` pulse per writing instruction. No `w_en` or `en_status` pulse in FETCH, HALT or ERR.

## Test plan
- Reset then MOV imm: `rst_n` low→high, pulse `start`, opcode 110/ALU_op 10, `mem_ready` = 1 → one cycle with `reg_sel` = 10, `wb_sel` = 10, `w_en` = 1; `waiting` returns 4 edges after the start edge.
- ADD with STATUS_ON_ALU = 0 and 1: opcode 101/00 → `en_A` then `en_B` then `en_C`, then WB with `reg_sel` = 01; `en_status` = 0 for the whole instruction with parameter 0, = 1 in EXEC with parameter 1; CMP asserts `en_status` and never `w_en`.
- LDR with 3 wait cycles: `mem_ready` low for 3 cycles in MEM_RD → `mem_cmd` = 01, `addr_sel` = 0 held 4 cycles, then LD_WB with `wb_sel` = 11, `w_en` = 1.
- Timeout: MEM_TIMEOUT = 4, STR with `mem_ready` stuck at 0 → exactly 4 MEM_WR cycles, then `err` = 1 held; `start` is ignored; `rst_n` clears to WAIT. Also check `mem_ready` = 1 in cycle 4 → normal completion, `err` stays 0.
- Illegal and halt opcodes: opcode 010 → `err` = 1 after DECODE; opcode 111 → `halted` = 1; neither issues `w_en`.
- Asynchronous reset mid-FETCH and mid-EXEC: `rst_n` pulled low between edges → `waiting` = 1 and `mem_cmd` = 00 immediately, with no clock edge needed.
